// File: rtl/ecc_ram_scrub_ctrl.sv
// Host access controller and background scrubber for the 2048x32 ECC RAM wrapper.
// Build option: define ECC_AUTO_WRITEBACK_EN to write corrected single-bit data back to the RAM.
module ecc_ram_scrub_ctrl #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 32,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic [DATA_W-1:0] RAM_WD,
    output logic [ADDR_W-1:0] RAM_WADDR,
    output logic              RAM_WEN,
    output logic [ADDR_W-1:0] RAM_RADDR,
    input  logic [DATA_W-1:0] RAM_RD,
    input  logic              RAM_SB_CORRECT,
    input  logic              RAM_DB_DETECT,
    input  logic              SCRUB_EN,
    input  logic              IRQ_CLR,
    output logic              DB_IRQ,
    output logic [ADDR_W-1:0] DB_ADDR,
    output logic [CNT_W-1:0]  SB_COUNT,
    output logic [CNT_W-1:0]  DB_COUNT
);

    localparam int              TIMER_W      = $clog2(SCRUB_INTERVAL);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(SCRUB_INTERVAL - 1);

`ifdef ECC_AUTO_WRITEBACK_EN
    typedef enum logic [1:0] {IDLE, HOST_RD, SCRUB_RD, WRITEBACK} state_e;
`else
    typedef enum logic [1:0] {IDLE, HOST_RD, SCRUB_RD} state_e;
`endif

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   scrub_ptr_q;
    logic [TIMER_W-1:0]  timer_q;
    logic                scrub_pending_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                db_irq_q;
    logic [ADDR_W-1:0]   db_addr_q;
    logic [CNT_W-1:0]    sb_count_q;
    logic [CNT_W-1:0]    db_count_q;
`ifdef ECC_AUTO_WRITEBACK_EN
    logic [DATA_W-1:0]   wb_data_q;
`endif

    // RAM port steering: host writes go straight through while idle, and a
    // write is never issued in a cycle that launches a checked read.
    always_comb begin
        REQ_READY = 1'b0;
        RAM_WEN   = 1'b0;
        RAM_WADDR = REQ_ADDR;
        RAM_WD    = REQ_WDATA;
        RAM_RADDR = REQ_ADDR;
        if (!RESET) begin
            case (state_q)
                IDLE: begin
                    REQ_READY = !scrub_pending_q;
                    if (scrub_pending_q) begin
                        RAM_RADDR = scrub_ptr_q;
                    end else if (REQ_VALID && REQ_WRITE) begin
                        RAM_WEN = 1'b1;
                    end
                end
`ifdef ECC_AUTO_WRITEBACK_EN
                WRITEBACK: begin
                    RAM_WEN   = 1'b1;
                    RAM_WADDR = addr_q;
                    RAM_WD    = wb_data_q;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            scrub_ptr_q     <= '0;
            timer_q         <= TIMER_RELOAD;
            scrub_pending_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
            db_irq_q        <= 1'b0;
            db_addr_q       <= '0;
            sb_count_q      <= '0;
            db_count_q      <= '0;
`ifdef ECC_AUTO_WRITEBACK_EN
            wb_data_q       <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            if (IRQ_CLR) begin
                db_irq_q <= 1'b0;
            end

            // The timer parks at zero with a scrub pending until the scrub is launched.
            if (state_q == IDLE && scrub_pending_q) begin
                timer_q         <= TIMER_RELOAD;
                scrub_pending_q <= 1'b0;
            end else if (SCRUB_EN) begin
                if (timer_q == '0) begin
                    scrub_pending_q <= 1'b1;
                end else begin
                    timer_q <= timer_q - 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (scrub_pending_q) begin
                        addr_q  <= scrub_ptr_q;
                        state_q <= SCRUB_RD;
                    end else if (REQ_VALID && !REQ_WRITE) begin
                        addr_q  <= REQ_ADDR;
                        state_q <= HOST_RD;
                    end
                end
                HOST_RD, SCRUB_RD: begin
                    if (state_q == HOST_RD) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= RAM_RD;
                        rsp_err_q   <= RAM_DB_DETECT;
                    end else begin
                        scrub_ptr_q <= scrub_ptr_q + 1'b1;
                    end
                    state_q <= IDLE;
                    // A double-bit error takes precedence and is never written back.
                    if (RAM_DB_DETECT) begin
                        if (db_count_q != '1) begin
                            db_count_q <= db_count_q + 1'b1;
                        end
                        db_irq_q  <= 1'b1;
                        db_addr_q <= addr_q;
                    end else if (RAM_SB_CORRECT) begin
                        if (sb_count_q != '1) begin
                            sb_count_q <= sb_count_q + 1'b1;
                        end
`ifdef ECC_AUTO_WRITEBACK_EN
                        wb_data_q <= RAM_RD;
                        state_q   <= WRITEBACK;
`endif
                    end
                end
`ifdef ECC_AUTO_WRITEBACK_EN
                WRITEBACK: begin
                    state_q <= IDLE;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;
    assign DB_IRQ    = db_irq_q;
    assign DB_ADDR   = db_addr_q;
    assign SB_COUNT  = sb_count_q;
    assign DB_COUNT  = db_count_q;

endmodule

// File: tb/tb_ecc_ram_scrub_ctrl.sv
// Scoreboard bench for ecc_ram_scrub_ctrl with a behavioural ECC RAM that injects flagged reads.
module tb_ecc_ram_scrub_ctrl;

    localparam int CNT_W = 3;
`ifdef ECC_AUTO_WRITEBACK_EN
    localparam int EXP_SCRUB_WAITS = 2;
`else
    localparam int EXP_SCRUB_WAITS = 1;
`endif

    logic        CLK;
    logic        RESET;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WRITE;
    logic [10:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [31:0] RAM_WD;
    logic [10:0] RAM_WADDR;
    logic        RAM_WEN;
    logic [10:0] RAM_RADDR;
    logic [31:0] RAM_RD;
    logic        RAM_SB_CORRECT;
    logic        RAM_DB_DETECT;
    logic        SCRUB_EN;
    logic        IRQ_CLR;
    logic        DB_IRQ;
    logic [10:0] DB_ADDR;
    logic [CNT_W-1:0] SB_COUNT;
    logic [CNT_W-1:0] DB_COUNT;

    ecc_ram_scrub_ctrl #(
        .ADDR_W(11), .DATA_W(32), .SCRUB_INTERVAL(4), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .RAM_WD(RAM_WD), .RAM_WADDR(RAM_WADDR), .RAM_WEN(RAM_WEN),
        .RAM_RADDR(RAM_RADDR), .RAM_RD(RAM_RD),
        .RAM_SB_CORRECT(RAM_SB_CORRECT), .RAM_DB_DETECT(RAM_DB_DETECT),
        .SCRUB_EN(SCRUB_EN), .IRQ_CLR(IRQ_CLR), .DB_IRQ(DB_IRQ),
        .DB_ADDR(DB_ADDR), .SB_COUNT(SB_COUNT), .DB_COUNT(DB_COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // RAM model: one-cycle read latency, flags forced low on write edges,
    // and a single injection address that returns flagged data.
    bit [31:0]   mem [2048];
    logic        injSb;
    logic        injDb;
    logic [10:0] injAddr;
    logic [31:0] injData;

    always @(posedge CLK) begin
        if (RAM_WEN) begin
            mem[RAM_WADDR] <= RAM_WD;
            RAM_SB_CORRECT <= 1'b0;
            RAM_DB_DETECT  <= 1'b0;
            RAM_RD         <= mem[RAM_RADDR];
        end else begin
            RAM_SB_CORRECT <= injSb && (RAM_RADDR == injAddr);
            RAM_DB_DETECT  <= injDb && (RAM_RADDR == injAddr);
            RAM_RD         <= (injSb && (RAM_RADDR == injAddr)) ? injData : mem[RAM_RADDR];
        end
    end

    typedef struct packed {logic [31:0] data; logic err;} rsp_t;
    typedef struct packed {logic [10:0] addr; logic [31:0] data;} wr_t;
    rsp_t rspQ[$];
    wr_t  wrQ[$];
    rsp_t monRsp;
    wr_t  monWr;
    int   checks = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expectRsp(input logic [31:0] data, input logic err);
        rspQ.push_back('{data: data, err: err});
    endtask

    task automatic expectWrite(input logic [10:0] addr, input logic [31:0] data);
        wrQ.push_back('{addr: addr, data: data});
    endtask

    // Monitor: every response pulse and every RAM write must match the head of its queue.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (RSP_VALID) begin
                if (rspQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rsp_unexpected: got data 0x%08h err %0b, required no response", RSP_RDATA, RSP_ERR);
                end else begin
                    monRsp = rspQ.pop_front();
                    checkOutput("rsp_rdata", RSP_RDATA, monRsp.data);
                    checkOutput("rsp_err", 32'(RSP_ERR), 32'(monRsp.err));
                end
            end
            if (RAM_WEN) begin
                if (wrQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL wen_unexpected: got write 0x%08h to 0x%03h, required no write", RAM_WD, RAM_WADDR);
                end else begin
                    monWr = wrQ.pop_front();
                    checkOutput("ram_waddr", 32'(RAM_WADDR), 32'(monWr.addr));
                    checkOutput("ram_wd", RAM_WD, monWr.data);
                end
            end
        end
    end

    // Presents one request and holds it until accepted; returns one cycle after acceptance.
    task automatic applyStimulus(input logic wr, input logic [10:0] addr, input logic [31:0] data, output int waits);
        bit accepted;
        accepted  = 1'b0;
        waits     = 0;
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = addr;
        REQ_WDATA = data;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge CLK);
            if (REQ_READY) accepted = 1'b1;
            else waits++;
            @(posedge CLK);
            #1;
        end
        REQ_VALID = 1'b0;
        REQ_WRITE = 1'b0;
        checks++;
        if (!accepted) begin
            failures++;
            $display("[TB] FAIL req_accept: got no acceptance of addr 0x%03h, required acceptance within 40 cycles", addr);
        end
    endtask

    task automatic doReset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: got no end of test, required completion before 1000000");
        $fatal(1, "[TB] timeout");
    end

    int  w;
    int  lastIssue;
    int  scrubIdx;
    bit  prevReady;
    bit  found;

    initial begin
        RESET = 1'b1; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
        SCRUB_EN = 1'b0; IRQ_CLR = 1'b0;
        injSb = 1'b0; injDb = 1'b0; injAddr = '0; injData = '0;

        @(negedge CLK);
        checkOutput("rst_ready", 32'(REQ_READY), 32'd0);
        checkOutput("rst_wen", 32'(RAM_WEN), 32'd0);
        checkOutput("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        checkOutput("rst_rsp_rdata", RSP_RDATA, 32'd0);
        checkOutput("rst_db_irq", 32'(DB_IRQ), 32'd0);
        checkOutput("rst_db_addr", 32'(DB_ADDR), 32'd0);
        checkOutput("rst_sb_count", 32'(SB_COUNT), 32'd0);
        checkOutput("rst_db_count", 32'(DB_COUNT), 32'd0);
        @(posedge CLK);
        #1 RESET = 1'b0;

        // Write then read back; response two cycles after acceptance.
        expectWrite(11'd5, 32'hDEADBEEF);
        applyStimulus(1'b1, 11'd5, 32'hDEADBEEF, w);
        expectRsp(32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 11'd5, 32'h0, w);
        @(negedge CLK);
        checkOutput("t1_rsp_early", 32'(RSP_VALID), 32'd0);
        @(negedge CLK);
        checkOutput("t1_rsp_valid", 32'(RSP_VALID), 32'd1);
        checkOutput("t1_sb_count", 32'(SB_COUNT), 32'd0);
        checkOutput("t1_db_count", 32'(DB_COUNT), 32'd0);
        @(posedge CLK); #1;

        // Back-to-back writes are accepted every cycle.
        expectWrite(11'd10, 32'h0000_0A0A);
        expectWrite(11'd11, 32'h0000_0B0B);
        applyStimulus(1'b1, 11'd10, 32'h0000_0A0A, w);
        applyStimulus(1'b1, 11'd11, 32'h0000_0B0B, w);
        checkOutput("t1_write_stream_wait", 32'(w), 32'd0);

        // Single-bit correction on a host read.
        injSb = 1'b1; injAddr = 11'd7; injData = 32'h12345678;
`ifdef ECC_AUTO_WRITEBACK_EN
        expectWrite(11'd7, 32'h12345678);
`endif
        expectRsp(32'h12345678, 1'b0);
        applyStimulus(1'b0, 11'd7, 32'h0, w);
        @(posedge CLK); #1;
`ifdef ECC_AUTO_WRITEBACK_EN
        @(negedge CLK);
        checkOutput("t2_ready_in_wb", 32'(REQ_READY), 32'd0);
`endif
        @(posedge CLK); #1;
        checkOutput("t2_sb_count", 32'(SB_COUNT), 32'd1);
        injSb = 1'b0;

        // Double-bit detection, then IRQ_CLR colliding with a new detection.
        injDb = 1'b1; injAddr = 11'h3FF;
        expectRsp(32'h0, 1'b1);
        applyStimulus(1'b0, 11'h3FF, 32'h0, w);
        @(posedge CLK); #1;
        checkOutput("t3_db_irq", 32'(DB_IRQ), 32'd1);
        checkOutput("t3_db_addr", 32'(DB_ADDR), 32'h3FF);
        checkOutput("t3_db_count", 32'(DB_COUNT), 32'd1);
        checkOutput("t3_sb_count", 32'(SB_COUNT), 32'd1);
        expectRsp(32'h0, 1'b1);
        applyStimulus(1'b0, 11'h3FF, 32'h0, w);
        IRQ_CLR = 1'b1;
        @(posedge CLK); #1;
        IRQ_CLR = 1'b0;
        checkOutput("t3_irq_set_wins", 32'(DB_IRQ), 32'd1);
        checkOutput("t3_db_count2", 32'(DB_COUNT), 32'd2);
        IRQ_CLR = 1'b1;
        @(posedge CLK); #1;
        IRQ_CLR = 1'b0;
        checkOutput("t3_irq_cleared", 32'(DB_IRQ), 32'd0);
        injDb = 1'b0;

        // Background scrub cadence and pointer wrap over a full sweep.
        doReset();
        SCRUB_EN  = 1'b1;
        prevReady = 1'b1;
        lastIssue = -1;
        scrubIdx  = 0;
        for (int cyc = 0; cyc < 12000 && scrubIdx < 2051; cyc++) begin
            @(negedge CLK);
            if (prevReady && !REQ_READY) begin
                checkOutput("t4_scrub_addr", 32'(RAM_RADDR), 32'(scrubIdx % 2048));
                if (lastIssue >= 0) checkOutput("t4_scrub_gap", 32'(cyc - lastIssue), 32'd5);
                lastIssue = cyc;
                scrubIdx++;
            end
            prevReady = REQ_READY;
        end
        checkOutput("t4_scrub_count", 32'(scrubIdx), 32'd2051);

        // A pending scrub holds off the host; the request goes in once it finishes.
        doReset();
        injSb = 1'b1; injAddr = 11'd0; injData = 32'hA5A5A5A5;
`ifdef ECC_AUTO_WRITEBACK_EN
        expectWrite(11'd0, 32'hA5A5A5A5);
`endif
        prevReady = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (prevReady && !REQ_READY) found = 1'b1;
            prevReady = REQ_READY;
        end
        checkOutput("t5_scrub_seen", 32'(found), 32'd1);
        @(posedge CLK); #1;
        expectRsp(32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 11'd5, 32'h0, w);
        injSb = 1'b0;
        SCRUB_EN = 1'b0;
        checkOutput("t5_host_wait", 32'(w), 32'(EXP_SCRUB_WAITS));
        @(posedge CLK); #1;
        checkOutput("t5_sb_count", 32'(SB_COUNT), 32'd1);
        repeat (8) @(posedge CLK);
        #1;

        // Reset asserted in the cycle after a corrected host read.
        injSb = 1'b1; injAddr = 11'd7; injData = 32'h0BADF00D;
        applyStimulus(1'b0, 11'd7, 32'h0, w);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        checkOutput("t5_rst_wen", 32'(RAM_WEN), 32'd0);
        checkOutput("t5_rst_rsp", 32'(RSP_VALID), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        injSb = 1'b0;
        @(negedge CLK);
        checkOutput("t5_idle_ready", 32'(REQ_READY), 32'd1);
        checkOutput("t5_sb_cleared", 32'(SB_COUNT), 32'd0);
        @(posedge CLK); #1;

        // Both flags at once: the double-bit path wins.
        injSb = 1'b1; injDb = 1'b1; injAddr = 11'd7; injData = 32'h12345678;
        expectRsp(32'h12345678, 1'b1);
        applyStimulus(1'b0, 11'd7, 32'h0, w);
        @(posedge CLK); #1;
        checkOutput("t6_both_db_count", 32'(DB_COUNT), 32'd1);
        checkOutput("t6_both_sb_count", 32'(SB_COUNT), 32'd0);
        injDb = 1'b0;

        // SB counter saturates at all-ones.
        for (int i = 0; i < 9; i++) begin
`ifdef ECC_AUTO_WRITEBACK_EN
            expectWrite(11'd7, 32'h12345678);
`endif
            expectRsp(32'h12345678, 1'b0);
            applyStimulus(1'b0, 11'd7, 32'h0, w);
        end
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("t6_sb_saturated", 32'(SB_COUNT), 32'd7);
        injSb = 1'b0;

        repeat (5) @(posedge CLK);
        #1;
        checkOutput("rsp_queue_drained", 32'(rspQ.size()), 32'd0);
        checkOutput("wr_queue_drained", 32'(wrQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_ram_scrub_ctrl.md
Name: ecc_ram_scrub_ctrl

Overview:
Access controller and background scrubber placed in front of the 2048x32 ECC two-port RAM wrapper. It takes host read/write requests through a valid/ready handshake and drives the RAM write and read ports. It consumes the RAM read data and the SB_CORRECT/DB_DETECT flags, writes corrected data back on single-bit errors, counts errors, and raises an interrupt when a double-bit error is detected.

Parameters:
ADDR_W, 11, RAM word address width (2048 words)
DATA_W, 32, RAM data width
SCRUB_INTERVAL, 1024, cycles between background scrub reads (must be >=2)
CNT_W, 16, width of the saturating error counters

Ports:
CLK in 1 single clock; all logic on posedge
RESET in 1 asynchronous, active-high reset
REQ_VALID in 1 host request valid
REQ_READY out 1 controller can accept a request
REQ_WRITE in 1 1=write, 0=read
REQ_ADDR in ADDR_W host word address
REQ_WDATA in DATA_W host write data
RSP_VALID out 1 one-cycle pulse: read data valid
RSP_RDATA out DATA_W read data (corrected)
RSP_ERR out 1 uncorrectable error on this read
RAM_WD out DATA_W to RAM WD
RAM_WADDR out ADDR_W to RAM WADDR
RAM_WEN out 1 to RAM WEN
RAM_RADDR out ADDR_W to RAM RADDR
RAM_RD in DATA_W from RAM RD
RAM_SB_CORRECT in 1 from RAM SB_CORRECT
RAM_DB_DETECT in 1 from RAM DB_DETECT
SCRUB_EN in 1 enables the background scrub timer
IRQ_CLR in 1 clears DB_IRQ
DB_IRQ out 1 sticky double-bit error interrupt
DB_ADDR out ADDR_W address of the most recent double-bit error
SB_COUNT out CNT_W saturating count of single-bit corrections
DB_COUNT out CNT_W saturating count of double-bit detections

Behaviour:
- Reset (async, RESET=1): state IDLE, REQ_READY=0, RAM_WEN=0, RSP_VALID=0, RSP_ERR=0, DB_IRQ=0, DB_ADDR=0, SB_COUNT=0, DB_COUNT=0, scrub pointer=0, timer=SCRUB_INTERVAL-1, scrub_pending=0. RSP_RDATA resets to 0.
- RAM timing: a RAM_RADDR sampled at edge N gives RAM_RD and the flags valid during cycle N+1. The RAM forces its flags to 0 when WEN was high at the same edge, so the controller never asserts RAM_WEN in a cycle in which it issues a checked read.
- States: IDLE, HOST_RD, SCRUB_RD, WRITEBACK.
- IDLE:
  - REQ_READY = !scrub_pending.
  - If scrub_pending: RAM_RADDR = scrub pointer, go to SCRUB_RD, reload the timer, clear scrub_pending.
  - Else if REQ_VALID & REQ_WRITE: RAM_WEN=1, RAM_WADDR=REQ_ADDR, RAM_WD=REQ_WDATA in the same cycle; remain in IDLE; no response.
  - Else if REQ_VALID & !REQ_WRITE: RAM_RADDR=REQ_ADDR, latch the address, go to HOST_RD.
  - Otherwise RAM_RADDR = REQ_ADDR and RAM_WEN=0.
- HOST_RD: REQ_READY=0.
  - RSP_VALID=1, RSP_RDATA=RAM_RD, RSP_ERR=RAM_DB_DETECT (all registered, visible in the next cycle).
  - Then apply the error evaluation.
- SCRUB_RD: REQ_READY=0.
  - Apply the error evaluation; no response is issued.
  - Scrub pointer increments and wraps from 2047 to 0.
- Error evaluation:
  - DB_DETECT=1: DB_COUNT++ (saturating), DB_IRQ=1, DB_ADDR=latched address, go to IDLE, no writeback.
  - Else SB_CORRECT=1: SB_COUNT++ (saturating), go to WRITEBACK.
  - Else: go to IDLE.
  - If both flags are set, the DB path wins.
- WRITEBACK: RAM_WEN=1, RAM_WADDR=latched address, RAM_WD=RAM_RD value captured during evaluation. REQ_READY=0. Go to IDLE after one cycle.
- Scrub timer:
  - Decrements each cycle while SCRUB_EN=1; holds while SCRUB_EN=0.
  - At 0 it sets scrub_pending. The timer keeps its value until the scrub is issued, then reloads.
- Counters saturate at all-ones; no wrap.
- IRQ_CLR and a new DB detection in the same cycle: the set wins (DB_IRQ=1).
- Host throughput: a write every cycle while idle; a read takes 2 cycles, or 3 with WRITEBACK.

Optional Feature:
ECC_AUTO_WRITEBACK_EN:
- Defined: behaviour is as described above.
- Undefined: the WRITEBACK state is removed. A single-bit correction still increments SB_COUNT and returns corrected data, but the controller goes directly to IDLE and never writes back.

Test Plan:
1. Reset, then host write 0xDEADBEEF to address 5, then read address 5 -> RSP_VALID pulses 2 cycles after acceptance, RSP_RDATA=0xDEADBEEF, RSP_ERR=0, counters stay 0.
2. Read address 7 with the RAM model asserting SB_CORRECT and RD=0x12345678 -> RSP_RDATA=0x12345678, SB_COUNT=1, next cycle RAM_WEN=1 with WADDR=7 and WD=0x12345678, REQ_READY=0 for that cycle.
3. Read address 0x3FF with DB_DETECT=1 -> RSP_ERR=1, DB_IRQ=1, DB_ADDR=0x3FF, DB_COUNT=1, no writeback. IRQ_CLR pulsed together with a second DB event -> DB_IRQ stays 1.
4. SCRUB_EN=1 with SCRUB_INTERVAL=4 and idle host -> a scrub read every 5 cycles at addresses 0,1,2,...; force the pointer to 2047 -> the next scrub reads 0.
5. Scrub pending while REQ_VALID is held -> REQ_READY=0 until the scrub completes, then the host request is accepted. Assert RESET during WRITEBACK -> RAM_WEN=0 immediately, state IDLE.
6. Force SB_COUNT to 0xFFFF, then inject an SB error -> SB_COUNT stays 0xFFFF. With ECC_AUTO_WRITEBACK_EN undefined, an SB error produces no RAM_WEN.
